// File: rtl/sms_clk_rst_ctl.sv
// -----------------------------------------------------------------------------
// sms_clk_rst_ctl
//
// Clock-enable and reset sequencer for the SMS core. The block runs on the
// 53.693175 MHz PLL output and qualifies it with the PLL lock flag. It holds
// the core in reset until lock has been stable for LOCK_HOLD cycles. It then
// produces single-cycle clock enables for the Z80 (/CPU_DIV), the VDP
// (/VDP_DIV) and the PSG (/PSG_DIV of the ungated CPU rate). This is the
// only consumer of the raw lock flag.
//
// Parameters:
//   LOCK_HOLD  clk_sys cycles lock must stay high before reset releases
//   CPU_DIV    clk_sys cycles per ce_cpu pulse (>= 2)
//   VDP_DIV    clk_sys cycles per ce_vdp pulse (>= 2)
//   PSG_DIV    ungated CPU-enable periods per ce_psg pulse (>= 1)
//
// Ports:
//   i_clk_sys        PLL output clock
//   i_rst_n          asynchronous active-low reset
//   i_pll_locked     PLL lock flag, asynchronous to i_clk_sys
//   i_pause          1 = suppress CPU/PSG enables (the counters keep running)
//   o_core_rst       synchronous active-high reset to the SMS core
//   o_ce_cpu         Z80 clock enable, one-cycle pulse
//   o_ce_vdp         VDP clock enable, one-cycle pulse
//   o_ce_psg         PSG clock enable, always coincident with a CPU slot
//   o_running        1 while in RUN
//   o_lock_loss_cnt  saturating count of lock losses
// -----------------------------------------------------------------------------
module sms_clk_rst_ctl #(
    parameter int LOCK_HOLD = 1024,
    parameter int CPU_DIV   = 15,
    parameter int VDP_DIV   = 10,
    parameter int PSG_DIV   = 16
) (
    input  logic       i_clk_sys,
    input  logic       i_rst_n,
    input  logic       i_pll_locked,
    input  logic       i_pause,
    output logic       o_core_rst,
    output logic       o_ce_cpu,
    output logic       o_ce_vdp,
    output logic       o_ce_psg,
    output logic       o_running,
    output logic [7:0] o_lock_loss_cnt
);

    localparam int CPU_W = (CPU_DIV > 2) ? $clog2(CPU_DIV) : 1;
    localparam int VDP_W = (VDP_DIV > 2) ? $clog2(VDP_DIV) : 1;
    localparam int PSG_W = (PSG_DIV > 2) ? $clog2(PSG_DIV) : 1;

    localparam logic [15:0]      HOLD_LAST = 16'(LOCK_HOLD - 1);
    localparam logic [CPU_W-1:0] CPU_LAST  = CPU_W'(CPU_DIV - 1);
    localparam logic [VDP_W-1:0] VDP_LAST  = VDP_W'(VDP_DIV - 1);
    localparam logic [PSG_W-1:0] PSG_LAST  = PSG_W'(PSG_DIV - 1);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_HOLD      = 2'd1,
        ST_RUN       = 2'd2
    } state_t;

    logic             r_sync_meta;
    logic             r_sync_q;
    state_t           r_state;
    logic [15:0]      r_hold_cnt;
    logic [CPU_W-1:0] r_cpu_cnt;
    logic [VDP_W-1:0] r_vdp_cnt;
    logic [PSG_W-1:0] r_psg_cnt;
    logic             r_core_rst;
    logic             r_ce_cpu;
    logic             r_ce_vdp;
    logic             r_ce_psg;
    logic             r_running;
    logic [7:0]       r_lock_loss_cnt;

    state_t           w_next_state;
    logic             w_lock_lost;
    logic             w_run_nxt;
    logic             w_cpu_tc;
    logic [15:0]      w_hold_cnt_nxt;
    logic [CPU_W-1:0] w_cpu_cnt_nxt;
    logic [VDP_W-1:0] w_vdp_cnt_nxt;
    logic [PSG_W-1:0] w_psg_cnt_nxt;

    // Two-flop synchronizer for the asynchronous lock flag. Everything
    // downstream looks only at r_sync_q.
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync_meta <= 1'b0;
            r_sync_q    <= 1'b0;
        end else begin
            r_sync_meta <= i_pll_locked;
            r_sync_q    <= r_sync_meta;
        end
    end

    // State register.
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_WAIT_LOCK;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic. Any loss of synchronized lock outside WAIT_LOCK
    // returns to WAIT_LOCK and is counted as a lock loss.
    always_comb begin
        w_next_state = r_state;
        w_lock_lost  = 1'b0;
        case (r_state)
            ST_WAIT_LOCK: begin
                if (r_sync_q) begin
                    w_next_state = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!r_sync_q) begin
                    w_next_state = ST_WAIT_LOCK;
                    w_lock_lost  = 1'b1;
                end else if (r_hold_cnt == HOLD_LAST) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!r_sync_q) begin
                    w_next_state = ST_WAIT_LOCK;
                    w_lock_lost  = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_WAIT_LOCK;
            end
        endcase
    end

    // Counter next values. The hold counter runs only while the FSM stays in
    // HOLD. The dividers run only while it stays in RUN, so they restart
    // from zero on every RUN entry and the enable phase after lock is
    // deterministic. The PSG counter advances on every raw CPU terminal
    // count, independent of pause.
    always_comb begin
        w_hold_cnt_nxt = '0;
        w_cpu_cnt_nxt  = '0;
        w_vdp_cnt_nxt  = '0;
        w_psg_cnt_nxt  = '0;
        w_cpu_tc       = (r_cpu_cnt == CPU_LAST);
        w_run_nxt      = (w_next_state == ST_RUN);

        if (r_state == ST_HOLD && w_next_state == ST_HOLD) begin
            w_hold_cnt_nxt = r_hold_cnt + 16'd1;
        end

        if (r_state == ST_RUN && w_run_nxt) begin
            w_cpu_cnt_nxt = w_cpu_tc ? '0 : r_cpu_cnt + CPU_W'(1);
            w_vdp_cnt_nxt = (r_vdp_cnt == VDP_LAST) ? '0 : r_vdp_cnt + VDP_W'(1);
            if (w_cpu_tc) begin
                w_psg_cnt_nxt = (r_psg_cnt == PSG_LAST) ? '0 : r_psg_cnt + PSG_W'(1);
            end else begin
                w_psg_cnt_nxt = r_psg_cnt;
            end
        end
    end

    // Counters and registered outputs. The enables are decoded from the
    // counter values that become current on this edge, so each pulse lines up
    // with the cycle in which its counter sits at terminal count. Because they
    // are gated with the next state, no pulse can appear once RUN is left.
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hold_cnt      <= '0;
            r_cpu_cnt       <= '0;
            r_vdp_cnt       <= '0;
            r_psg_cnt       <= '0;
            r_core_rst      <= 1'b1;
            r_running       <= 1'b0;
            r_ce_cpu        <= 1'b0;
            r_ce_vdp        <= 1'b0;
            r_ce_psg        <= 1'b0;
            r_lock_loss_cnt <= '0;
        end else begin
            r_hold_cnt <= w_hold_cnt_nxt;
            r_cpu_cnt  <= w_cpu_cnt_nxt;
            r_vdp_cnt  <= w_vdp_cnt_nxt;
            r_psg_cnt  <= w_psg_cnt_nxt;
            r_core_rst <= !w_run_nxt;
            r_running  <= w_run_nxt;
            r_ce_cpu   <= w_run_nxt && (w_cpu_cnt_nxt == CPU_LAST) && !i_pause;
            r_ce_vdp   <= w_run_nxt && (w_vdp_cnt_nxt == VDP_LAST);
            r_ce_psg   <= w_run_nxt && (w_cpu_cnt_nxt == CPU_LAST)
                          && (w_psg_cnt_nxt == PSG_LAST) && !i_pause;
            if (w_lock_lost && r_lock_loss_cnt != 8'hFF) begin
                r_lock_loss_cnt <= r_lock_loss_cnt + 8'd1;
            end
        end
    end

    assign o_core_rst      = r_core_rst;
    assign o_ce_cpu        = r_ce_cpu;
    assign o_ce_vdp        = r_ce_vdp;
    assign o_ce_psg        = r_ce_psg;
    assign o_running       = r_running;
    assign o_lock_loss_cnt = r_lock_loss_cnt;

endmodule

// File: doc/sms_clk_rst_ctl.md
# sms_clk_rst_ctl

Clock-enable and reset sequencer fed by the core PLL: runs on the 53.693175 MHz PLL output and qualifies it with the PLL lock flag. Holds the SMS core in reset until lock has been stable for a programmable time. Then generates the single-cycle clock enables for the Z80 (÷15, 3.579545 MHz), the VDP (÷10, 5.369318 MHz) and the PSG (÷16 of the CPU rate). Sits between the PLL wrapper and every SMS core block; no other block consumes the raw lock flag.

## Interface
- LOCK_HOLD, 1024: clk_sys cycles lock must stay high before core reset releases (1..65535)
- CPU_DIV, 15: clk_sys cycles per ce_cpu pulse (≥2)
- VDP_DIV, 10: clk_sys cycles per ce_vdp pulse (≥2)
- PSG_DIV, 16: ungated CPU-enable periods per ce_psg pulse (≥1)

- clk_sys  in  1  53.693175 MHz PLL output clock
- rst_n  in  1  asynchronous active-low reset
- pll_locked  in  1  PLL lock flag, asynchronous to clk_sys
- pause  in  1  synchronous to clk_sys; 1 = freeze CPU/PSG enables
- core_rst  out  1  synchronous active-high reset to SMS core
- ce_cpu  out  1  Z80 clock enable, one-cycle pulse
- ce_vdp  out  1  VDP clock enable, one-cycle pulse
- ce_psg  out  1  PSG clock enable, one-cycle pulse, coincident with a ce_cpu slot
- running  out  1  1 while in RUN state
- lock_loss_cnt  out  8  saturating count of lock losses after first lock

## Operation
- pll_locked passes through a 2-flop synchronizer (sync_q, reset 0); all logic uses sync_q.
- States:
  - WAIT_LOCK (reset state): hold counter = 0, all divider counters = 0.
    - sync_q=1 → HOLD.
  - HOLD: hold counter increments each cycle.
    - sync_q=0 → WAIT_LOCK, lock_loss_cnt+1.
    - Counter = LOCK_HOLD−1 with sync_q=1 → RUN.
  - RUN: dividers run.
    - sync_q=0 → WAIT_LOCK, lock_loss_cnt+1.
- core_rst = 1 in WAIT_LOCK and HOLD, 0 in RUN (registered from state).
- running = 1 in RUN only.
- All ce outputs are 0 outside RUN.
- Dividers run only in RUN and are cleared to 0 on every RUN entry, so phase is deterministic after each lock.
  - cpu_cnt 0..CPU_DIV−1, wraps.
  - vdp_cnt 0..VDP_DIV−1, wraps.
  - psg_cnt 0..PSG_DIV−1, advances on each raw (ungated) CPU terminal count.
- Outputs are registered:
  - ce_cpu = cpu terminal count AND NOT pause.
  - ce_vdp = vdp terminal count.
  - ce_psg = cpu terminal count AND psg_cnt=PSG_DIV−1 AND NOT pause.
- pause does not stop the counters; CPU/PSG phase is preserved across pause.
- lock_loss_cnt saturates at 255. It is cleared only by rst_n; WAIT_LOCK entry does not clear it.

## Timing
- rst_n low: all registers clear immediately (async).
  - State = WAIT_LOCK, core_rst=1, all ce=0, running=0, lock_loss_cnt=0.
  - Release is synchronous to clk_sys; no reset synchronizer is required inside this block.
- pll_locked rise → sync_q after 2 edges → HOLD on the next edge.
- core_rst falls LOCK_HOLD cycles after HOLD entry.
- First ce_cpu high cycle: the CPU_DIV-th cycle with core_rst=0. First ce_vdp high cycle: the VDP_DIV-th cycle.
- Steady state: ce_cpu period exactly CPU_DIV, ce_vdp period VDP_DIV, ce_psg period CPU_DIV×PSG_DIV (240 clk_sys at defaults). Each pulse is 1 cycle wide.
- Lock loss in RUN: the state leaves RUN 3 edges after the pll_locked fall (2 sync + 1). core_rst=1 and all ce=0 from that cycle on; no partial pulse afterwards.
- pause change takes effect on the next registered output (1 cycle latency). A terminal count coinciding with pause=1 is dropped, not deferred.
- Lock glitch shorter than 2 clk_sys cycles may be filtered by the synchronizer. If it is captured, it must count as a loss.

## Test plan
- Lock sequence: rst_n low 5 cycles, raise pll_locked, LOCK_HOLD=16 → core_rst falls 19 cycles after pll_locked rise ±1. First ce_cpu 15 cycles later, first ce_vdp 10 cycles later.
- Periods: run 2400 cycles in RUN → exactly 160 ce_cpu, 240 ce_vdp, 10 ce_psg; every ce_psg coincident with a ce_cpu.
- Drop in HOLD: pll_locked low at HOLD cycle 8 → state returns to WAIT_LOCK, core_rst never falls, lock_loss_cnt=1. Relock → full LOCK_HOLD wait restarts.
- Drop in RUN: pll_locked low → core_rst=1 and ce_* all 0 within 3 cycles. lock_loss_cnt increments. After relock, the first ce_cpu is again CPU_DIV cycles after core_rst falls.
- Pause: pause=1 for 100 cycles → zero ce_cpu/ce_psg and 10 ce_vdp. After release, ce_cpu spacing is unchanged relative to the pre-pause phase.
- Saturation/async reset: 300 lock losses → lock_loss_cnt=255. rst_n pulse mid-RUN → all outputs at reset values before the next clk_sys edge.
